// File: rtl/lfm_chirp_transmitter.sv
// Complex linear-FM chirp pulse-train generator: a quadratic-phase accumulator
// addresses a cosine table, and an IDLE/PULSE/LISTEN sequencer frames each PRI.
module lfm_chirp_transmitter #(
    parameter int unsigned             DATA_WIDTH     = 18,
    parameter int unsigned             PULSE_LENGTH   = 10000,
    parameter int unsigned             PRI_LENGTH     = 330000,
    parameter int unsigned             PHASE_WIDTH    = 32,
    parameter int unsigned             LUT_ADDR_WIDTH = 10,
    parameter logic [PHASE_WIDTH-1:0]  START_FREQ     = 32'h0100_0000,
    parameter logic [PHASE_WIDTH-1:0]  CHIRP_RATE     = 32'h0000_0040
) (
    input  logic                         clock,
    input  logic                         resetN,
    input  logic                         enable,
    input  logic                         sampleTick,
    output logic signed [DATA_WIDTH-1:0] chirpOutRe,
    output logic signed [DATA_WIDTH-1:0] chirpOutIm,
    output logic                         chirpValid,
    output logic                         pulseStart,
    output logic                         busy,
    output logic [15:0]                  pulseCount
);

    localparam int unsigned LUT_DEPTH     = 32'd1 << LUT_ADDR_WIDTH;
    localparam int unsigned QUARTER_DEPTH = LUT_DEPTH / 32'd4;
    localparam logic [LUT_ADDR_WIDTH-1:0] QUARTER_ADDR = LUT_ADDR_WIDTH'(QUARTER_DEPTH);
    localparam int          CNT_W         = $clog2(PRI_LENGTH);
    localparam int          FRAC_BITS     = 30;
    localparam longint      ONE_Q         = 64'sd1 <<< FRAC_BITS;
    localparam longint      HALF_Q        = 64'sd1 <<< (FRAC_BITS - 1);
    localparam longint      PI_Q          = 64'sd3373259426;
    localparam longint      AMPLITUDE     = (64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1;

    // Elaboration-time table entry: quadrant-folded Taylor series in Q30 fixed
    // point, so quadrant boundaries land on exact 0 / full scale.
    function automatic logic signed [DATA_WIDTH-1:0] lut_value(input int unsigned k);
        logic [1:0] quad;
        longint     x;
        longint     x2;
        longint     term;
        longint     c;
        longint     s;
        longint     v;
        longint     mag;
        quad = 2'(k / QUARTER_DEPTH);
        x    = (64'sd2 * PI_Q * longint'(k % QUARTER_DEPTH)) / longint'(LUT_DEPTH);
        x2   = (x * x) >>> FRAC_BITS;
        c    = ONE_Q;
        term = ONE_Q;
        for (int i = 1; i <= 32'sd12; i++) begin
            term = ((term * x2) >>> FRAC_BITS) / longint'((32'sd2 * i - 32'sd1) * (32'sd2 * i));
            c    = i[0] ? (c - term) : (c + term);
        end
        s    = x;
        term = x;
        for (int i = 1; i <= 32'sd12; i++) begin
            term = ((term * x2) >>> FRAC_BITS) / longint'((32'sd2 * i) * (32'sd2 * i + 32'sd1));
            s    = i[0] ? (s - term) : (s + term);
        end
        case (quad)
            2'd0:    v = c;
            2'd1:    v = -s;
            2'd2:    v = -c;
            default: v = s;
        endcase
        mag = (v < 64'sd0) ? -v : v;
        mag = (mag * AMPLITUDE + HALF_Q) >>> FRAC_BITS;
        lut_value = (v < 64'sd0) ? DATA_WIDTH'(-mag) : DATA_WIDTH'(mag);
    endfunction

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PULSE  = 2'd1,
        LISTEN = 2'd2
    } state_t;

    logic signed [DATA_WIDTH-1:0] lut_s [LUT_DEPTH];

    for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_lut
        localparam logic signed [DATA_WIDTH-1:0] ENTRY = lut_value(32'(k));
        assign lut_s[k] = ENTRY;
    end

    state_t                    state_r;
    state_t                    state_next_s;
    logic [PHASE_WIDTH-1:0]    phase_r;
    logic [PHASE_WIDTH-1:0]    phase_next_s;
    logic [PHASE_WIDTH-1:0]    freq_r;
    logic [PHASE_WIDTH-1:0]    freq_next_s;
    logic [CNT_W-1:0]          count_r;
    logic [CNT_W-1:0]          count_next_s;
    logic [15:0]               pulse_count_r;
    logic [15:0]               pulse_count_next_s;
    logic                      issue_s;
    logic                      start_s;
    logic [LUT_ADDR_WIDTH-1:0] addr_s;

    logic [LUT_ADDR_WIDTH-1:0] addr_r;
    logic [LUT_ADDR_WIDTH-1:0] im_addr_s;
    logic                      valid1_r;
    logic                      start1_r;
    logic signed [DATA_WIDTH-1:0] re_r;
    logic signed [DATA_WIDTH-1:0] im_r;
    logic                      valid_r;
    logic                      start_out_r;
    logic                      busy_r;

    // Sequencer next-state and accumulator update; nothing moves without a tick.
    always_comb begin
        state_next_s       = state_r;
        phase_next_s       = phase_r;
        freq_next_s        = freq_r;
        count_next_s       = count_r;
        pulse_count_next_s = pulse_count_r;
        issue_s            = 1'b0;
        start_s            = 1'b0;
        addr_s             = phase_r[PHASE_WIDTH-1 -: LUT_ADDR_WIDTH];
        if (sampleTick) begin
            case (state_r)
                IDLE: begin
                    if (enable) begin
                        // The starting tick is itself sample 0 at phase 0.
                        issue_s      = 1'b1;
                        start_s      = 1'b1;
                        addr_s       = {LUT_ADDR_WIDTH{1'b0}};
                        phase_next_s = START_FREQ;
                        freq_next_s  = START_FREQ + CHIRP_RATE;
                        count_next_s = CNT_W'(1);
                        if (PULSE_LENGTH == 32'd1) begin
                            state_next_s       = LISTEN;
                            pulse_count_next_s = pulse_count_r + 16'd1;
                        end else begin
                            state_next_s = PULSE;
                        end
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                PULSE: begin
                    issue_s      = 1'b1;
                    start_s      = (count_r == {CNT_W{1'b0}});
                    phase_next_s = phase_r + freq_r;
                    freq_next_s  = freq_r + CHIRP_RATE;
                    count_next_s = count_r + CNT_W'(1);
                    if (count_r == CNT_W'(PULSE_LENGTH - 32'd1)) begin
                        state_next_s       = LISTEN;
                        pulse_count_next_s = pulse_count_r + 16'd1;
                    end else begin
                        state_next_s = PULSE;
                    end
                end
                LISTEN: begin
                    if (count_r == CNT_W'(PRI_LENGTH - 32'd1)) begin
                        phase_next_s = {PHASE_WIDTH{1'b0}};
                        freq_next_s  = START_FREQ;
                        count_next_s = {CNT_W{1'b0}};
                        state_next_s = enable ? PULSE : IDLE;
                    end else begin
                        count_next_s = count_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_next_s = IDLE;
                end
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // Sequencer and accumulator registers.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_r       <= IDLE;
            phase_r       <= {PHASE_WIDTH{1'b0}};
            freq_r        <= START_FREQ;
            count_r       <= {CNT_W{1'b0}};
            pulse_count_r <= 16'd0;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            phase_r       <= phase_next_s;
            freq_r        <= freq_next_s;
            count_r       <= count_next_s;
            pulse_count_r <= pulse_count_next_s;
            busy_r        <= (state_next_s != IDLE);
        end
    end

    assign im_addr_s = addr_r - QUARTER_ADDR;

    // Two-stage output pipeline: address register, then gated table lookup.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            addr_r      <= {LUT_ADDR_WIDTH{1'b0}};
            valid1_r    <= 1'b0;
            start1_r    <= 1'b0;
            re_r        <= {DATA_WIDTH{1'b0}};
            im_r        <= {DATA_WIDTH{1'b0}};
            valid_r     <= 1'b0;
            start_out_r <= 1'b0;
        end else begin
            addr_r      <= issue_s ? addr_s : {LUT_ADDR_WIDTH{1'b0}};
            valid1_r    <= issue_s;
            start1_r    <= start_s;
            re_r        <= valid1_r ? lut_s[addr_r] : {DATA_WIDTH{1'b0}};
            im_r        <= valid1_r ? lut_s[im_addr_s] : {DATA_WIDTH{1'b0}};
            valid_r     <= valid1_r;
            start_out_r <= start1_r & valid1_r;
        end
    end

    assign chirpOutRe = re_r;
    assign chirpOutIm = im_r;
    assign chirpValid = valid_r;
    assign pulseStart = start_out_r;
    assign busy       = busy_r;
    assign pulseCount = pulse_count_r;

endmodule

// File: tb/tb_lfm_chirp_transmitter.sv
// Scoreboard bench: two transmitters (chirp rate 0 and 2^28) driven in lockstep;
// expected samples are queued at each tick and checked by a free-running monitor.
`timescale 1ns/1ps
module tb_lfm_chirp_transmitter;

    localparam int PL  = 8;
    localparam int PRI = 20;

    typedef struct {
        int re;
        int im;
        bit start;
        int due;
    } exp_t;

    logic clock      = 1'b0;
    logic resetN     = 1'b0;
    logic enable     = 1'b0;
    logic sampleTick = 1'b0;

    logic signed [17:0] re_lin, im_lin, re_qd, im_qd;
    logic valid_lin, valid_qd, start_lin, start_qd, busy_lin, busy_qd;
    logic [15:0] cnt_lin, cnt_qd;

    // Hand-computed table: round(131071*cos(2*pi*k/16)).
    int LUT16 [16] = '{131071, 121094, 92681, 50159, 0, -50159, -92681, -121094,
                       -131071, -121094, -92681, -50159, 0, 50159, 92681, 121094};
    // n(n+1)/2 mod 16 for the 2^28 chirp rate.
    int ADDR_QD [8] = '{0, 1, 3, 6, 10, 15, 5, 12};

    exp_t q_lin [$];
    exp_t q_qd  [$];
    exp_t e_lin;
    exp_t e_qd;
    int   start_cycles [$];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int m_st        = 0;
    int m_cnt       = 0;

    lfm_chirp_transmitter #(
        .DATA_WIDTH(18), .PULSE_LENGTH(PL), .PRI_LENGTH(PRI), .PHASE_WIDTH(32),
        .LUT_ADDR_WIDTH(4), .START_FREQ(32'h1000_0000), .CHIRP_RATE(32'h0000_0000)
    ) dut_lin (
        .clock(clock), .resetN(resetN), .enable(enable), .sampleTick(sampleTick),
        .chirpOutRe(re_lin), .chirpOutIm(im_lin), .chirpValid(valid_lin),
        .pulseStart(start_lin), .busy(busy_lin), .pulseCount(cnt_lin)
    );

    lfm_chirp_transmitter #(
        .DATA_WIDTH(18), .PULSE_LENGTH(PL), .PRI_LENGTH(PRI), .PHASE_WIDTH(32),
        .LUT_ADDR_WIDTH(4), .START_FREQ(32'h1000_0000), .CHIRP_RATE(32'h1000_0000)
    ) dut_qd (
        .clock(clock), .resetN(resetN), .enable(enable), .sampleTick(sampleTick),
        .chirpOutRe(re_qd), .chirpOutIm(im_qd), .chirpValid(valid_qd),
        .pulseStart(start_qd), .busy(busy_qd), .pulseCount(cnt_qd)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic compare_sample(input string tag, input exp_t e, input logic v,
                                  input int re, input int im, input logic st);
        check({tag, " valid"}, int'(v), 1);
        check({tag, " time"}, cyc, e.due);
        check({tag, " re"}, re, e.re);
        check({tag, " im"}, im, e.im);
        check({tag, " pulseStart"}, int'(st), int'(e.start));
    endtask

    task automatic push_sample(input int n);
        exp_t e;
        e.start = (n == 0);
        e.due   = cyc + 2;
        e.re    = LUT16[n];
        e.im    = LUT16[(n + 12) % 16];
        q_lin.push_back(e);
        e.re    = LUT16[ADDR_QD[n]];
        e.im    = LUT16[(ADDR_QD[n] + 12) % 16];
        q_qd.push_back(e);
    endtask

    task automatic model_step();
        case (m_st)
            0: if (enable) begin
                push_sample(0);
                m_cnt = 1;
                m_st  = 1;
            end
            1: begin
                push_sample(m_cnt);
                if (m_cnt == PL - 1) m_st = 2;
                m_cnt++;
            end
            default: begin
                if (m_cnt == PRI - 1) begin
                    m_cnt = 0;
                    m_st  = enable ? 1 : 0;
                end else begin
                    m_cnt++;
                end
            end
        endcase
    endtask

    task automatic tick_once(input int spacing);
        sampleTick = 1'b1;
        model_step();
        @(negedge clock);
        sampleTick = 1'b0;
        repeat (spacing - 1) @(negedge clock);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " lin re"}, re_lin, 0);
        check({tag, " lin im"}, im_lin, 0);
        check({tag, " lin valid/start/busy"}, int'({valid_lin, start_lin, busy_lin}), 0);
        check({tag, " lin pulseCount"}, cnt_lin, 0);
        check({tag, " qd re"}, re_qd, 0);
        check({tag, " qd im"}, im_qd, 0);
        check({tag, " qd valid/start/busy"}, int'({valid_qd, start_qd, busy_qd}), 0);
        check({tag, " qd pulseCount"}, cnt_qd, 0);
    endtask

    // Monitor: pops an expected sample whenever a DUT presents one or one is overdue.
    always @(negedge clock) begin
        if (resetN) begin
            if (valid_lin || (q_lin.size() > 0 && q_lin[0].due <= cyc)) begin
                if (q_lin.size() == 0) begin
                    check("lin unexpected valid", int'(valid_lin), 0);
                end else begin
                    e_lin = q_lin.pop_front();
                    compare_sample("lin", e_lin, valid_lin, re_lin, im_lin, start_lin);
                end
                if (valid_lin && start_lin) start_cycles.push_back(cyc);
            end else begin
                check("lin gated outputs", int'(re_lin != 18'sd0 || im_lin != 18'sd0 || start_lin), 0);
            end
            if (valid_qd || (q_qd.size() > 0 && q_qd[0].due <= cyc)) begin
                if (q_qd.size() == 0) begin
                    check("qd unexpected valid", int'(valid_qd), 0);
                end else begin
                    e_qd = q_qd.pop_front();
                    compare_sample("qd", e_qd, valid_qd, re_qd, im_qd, start_qd);
                end
            end else begin
                check("qd gated outputs", int'(re_qd != 18'sd0 || im_qd != 18'sd0 || start_qd), 0);
            end
        end
    end

    initial begin
        repeat (3) @(negedge clock);
        check_quiet("reset");
        resetN = 1'b1;
        @(negedge clock);

        // Continuous ticks: two full PRIs, then enable drops during the third.
        enable = 1'b1;
        repeat (PL) tick_once(1);
        check("qd pulseCount after pulse 1", cnt_qd, 1);
        check("busy during listen", int'({busy_lin, busy_qd}), 3);
        repeat (PRI - PL) tick_once(1);
        repeat (PRI) tick_once(1);
        check("starts after 2 PRIs", start_cycles.size(), 2);
        if (start_cycles.size() >= 2)
            check("PRI spacing back-to-back", start_cycles[1] - start_cycles[0], PRI);
        check("pulseCount after 2 PRIs", cnt_lin, 2);
        repeat (3) tick_once(1);
        enable = 1'b0;
        repeat (16) tick_once(1);
        check("busy before tick 19", int'({busy_lin, busy_qd}), 3);
        tick_once(1);
        check("busy after tick 19", int'({busy_lin, busy_qd}), 0);
        repeat (25) tick_once(1);
        check("no pulse after enable drop", start_cycles.size(), 3);
        check("pulseCount after 3 PRIs", cnt_qd, 3);

        // Tick every third clock.
        start_cycles.delete();
        enable = 1'b1;
        repeat (PRI + 1) tick_once(3);
        enable = 1'b0;
        check("starts with sparse ticks", start_cycles.size(), 2);
        if (start_cycles.size() >= 2)
            check("PRI spacing sparse ticks", start_cycles[1] - start_cycles[0], 3 * PRI);
        repeat (PRI - 1) tick_once(3);
        check("idle after sparse PRIs", int'({busy_lin, busy_qd}), 0);
        check("pulseCount after sparse PRIs", cnt_lin, 5);

        // Asynchronous reset during sample 5.
        enable = 1'b1;
        repeat (6) tick_once(1);
        #2;
        resetN = 1'b0;
        #1;
        check_quiet("mid-pulse reset");
        q_lin.delete();
        q_qd.delete();
        m_st  = 0;
        m_cnt = 0;
        repeat (2) @(negedge clock);
        resetN = 1'b1;
        start_cycles.delete();
        repeat (PRI - 1) tick_once(1);
        enable = 1'b0;
        tick_once(1);
        check("start after reset", start_cycles.size(), 1);
        check("pulseCount after reset PRI", cnt_qd, 1);

        // pulseCount wrap from 65535.
        force dut_lin.pulse_count_r = 16'hFFFF;
        force dut_qd.pulse_count_r  = 16'hFFFF;
        @(negedge clock);
        release dut_lin.pulse_count_r;
        release dut_qd.pulse_count_r;
        @(negedge clock);
        check("pulseCount preset", cnt_qd, 65535);
        enable = 1'b1;
        repeat (PL) tick_once(1);
        enable = 1'b0;
        check("pulseCount wrap lin", cnt_lin, 0);
        check("pulseCount wrap qd", cnt_qd, 0);
        repeat (PRI - PL) tick_once(1);
        repeat (4) @(negedge clock);
        check("lin queue drained", q_lin.size(), 0);
        check("qd queue drained", q_qd.size(), 0);
        check("idle at end", int'({busy_lin, busy_qd}), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
